// File: rtl/fpjh_src_arb.sv
// Packet-granular round-robin arbiter that shares one fpjhSend engine between
// NUM_SRC AXIS sources. The grant is held from arbitration through the tlast beat.
module fpjh_src_arb #(
  parameter int NUM_SRC  = 4,
  parameter int IDLE_GAP = 0,
  parameter int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC*12-1:0] s_length,
  input  logic [NUM_SRC*32-1:0] s_axis_tdata,
  input  logic [NUM_SRC*4-1:0]  s_axis_tkeep,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  input  logic [NUM_SRC-1:0]    s_axis_tlast,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  output logic [11:0]           m_length,
  output logic [31:0]           m_axis_tdata,
  output logic [3:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [SRC_W-1:0]      m_src_id,
  output logic                  o_len_err
);
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

  localparam logic [7:0] GAP_LOAD = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

  state_t           r_state, w_next;
  logic [SRC_W-1:0] r_grant, r_last_grant, w_pick;
  logic             w_any;
  logic [11:0]      r_m_length, w_pick_len;
  logic [13:0]      r_byte_cnt, w_cnt_next;
  logic [7:0]       r_gap_cnt;
  logic             r_len_err;
  logic [31:0]      w_g_data;
  logic [3:0]       w_g_keep;
  logic             w_g_valid, w_g_last, w_xfer, w_beat, w_mismatch;
  logic [2:0]       w_pop;
  logic [14:0]      w_sum;

  // Round robin: the smallest nonzero offset from last_grant wins, so scan far to near.
  always_comb begin
    w_pick     = '0;
    w_pick_len = '0;
    w_any      = 1'b0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (s_axis_tvalid[k] && ((int'(r_last_grant) + i) % NUM_SRC == k)) begin
          w_pick     = SRC_W'(k);
          w_pick_len = s_length[12*k +: 12];
          w_any      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_g_data  = '0;
    w_g_keep  = '0;
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_grant == SRC_W'(k)) begin
        w_g_data  = s_axis_tdata[32*k +: 32];
        w_g_keep  = s_axis_tkeep[4*k +: 4];
        w_g_valid = s_axis_tvalid[k];
        w_g_last  = s_axis_tlast[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_xfer        = (r_state == S_XFER);
    m_axis_tvalid = w_xfer & w_g_valid;
    m_axis_tdata  = w_xfer ? w_g_data : '0;
    m_axis_tkeep  = w_xfer ? w_g_keep : '0;
    m_axis_tlast  = w_xfer & w_g_last;
    s_axis_tready = '0;
    for (int k = 0; k < NUM_SRC; k++)
      s_axis_tready[k] = w_xfer && (r_grant == SRC_W'(k)) && m_axis_tready;
    w_beat = m_axis_tvalid & m_axis_tready;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_XFER;
      S_XFER:  if (w_beat && m_axis_tlast) w_next = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gap_cnt == 8'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The tlast beat's own bytes are folded in before comparing to the declared length.
  assign w_pop      = 3'($countones(m_axis_tkeep));
  assign w_sum      = {1'b0, r_byte_cnt} + 15'(w_pop);
  assign w_cnt_next = (w_sum > 15'd16383) ? 14'h3FFF : w_sum[13:0];
  assign w_mismatch = (w_sum != {3'b000, r_m_length});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= SRC_W'(NUM_SRC - 1);
      r_m_length   <= '0;
      r_byte_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_len_err    <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_grant    <= w_pick;
          r_m_length <= w_pick_len;
          r_byte_cnt <= '0;
        end
        S_XFER: if (w_beat) begin
          r_byte_cnt <= w_cnt_next;
          if (m_axis_tlast) begin
            r_last_grant <= r_grant;
            r_len_err    <= w_mismatch;
            r_gap_cnt    <= GAP_LOAD;
          end
        end
        S_GAP: if (r_gap_cnt != 8'd0) r_gap_cnt <= r_gap_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  assign m_length  = r_m_length;
  assign m_src_id  = r_grant;
  assign o_len_err = r_len_err;
endmodule
